link_hang_watchdog: RTL and testbench
=====================================

// Module: link_hang_watchdog
// PURPOSE
// - Passive monitor on one credit-based router link (tx/cr/eop/data).
// - Detects hang episodes: the sender holds a flit for too long and no credit returns.
// - Sits on the sender side of a link, in parallel with the link wires, and never drives them.
// - Reports the hang: sticky flag, header of the stalled packet, position in the packet,
//   episode length, and an episode count.
// PARAMETERS
// - ADDRESS      16'b0  router address [15:8]=X, [7:0]=Y; used only in log messages
// - PORT         ""     port name string; used only in log messages
// - STALL_LIMIT  64     number of consecutive stall cycles that declares a hang; >=1
// - CNT_W        16     width of the length and event counters
// PORTS
// - clk_i          in   1      clock
// - rst_ni         in   1      async reset, active low
// - tx_i           in   1      sender flit valid
// - cr_rx_i        in   1      receiver credit; a flit transfers when tx_i && cr_rx_i
// - eop_tx_i       in   1      last flit of the packet
// - data_tx_i      in   32     flit data
// - hang_ack_i     in   1      clears hang_o
// - hang_o         out  1      sticky hang flag
// - hang_active_o  out  1      high while the current stall episode is at or past the limit
// - hang_header_o  out  32     header flit of the stalled packet
// - hang_pos_o     out  2      packet position at detection: 0=HEADER 1=SIZE 2=SERVICE 3=PAYLOAD
// - hang_len_o     out  CNT_W  stall cycles of the current or last episode, saturating
// - hang_events_o  out  CNT_W  number of detected episodes, saturating
// BEHAVIOUR
// - Reset: all outputs 0; framing FSM = HEADER; stall_cnt = 0; header register = 0.
// - Definitions: xfer = tx_i && cr_rx_i; stall = tx_i && !cr_rx_i.
// - Framing FSM (advances on xfer only):
//   - HEADER->SIZE, SIZE->SERVICE, SERVICE->PAYLOAD, PAYLOAD holds.
//   - xfer && eop_tx_i returns to HEADER from any state; this has priority.
// - Header register loads data_tx_i on xfer while the FSM is in HEADER.
// - stall_cnt (saturates at 2^CNT_W-1):
//   - cleared on xfer or when !tx_i;
//   - otherwise +1 on each stall cycle.
// - Detection:
//   - Fires when stall && stall_cnt==STALL_LIMIT-1.
//   - hang_o rises at the next edge, i.e. after exactly STALL_LIMIT consecutive stall cycles.
//   - At that same edge: hang_active_o<=1, hang_header_o<=header register
//     (data_tx_i if the FSM is in HEADER), hang_pos_o<=FSM state, hang_events_o+1.
//   - Only one detection per episode.
// - While hang_active_o=1: hang_len_o tracks stall_cnt+1, saturating.
// - Episode end:
//   - xfer or !tx_i clears hang_active_o at the next edge.
//   - hang_len_o, hang_header_o and hang_pos_o hold until the next detection.
// - hang_o: sticky until hang_ack_i. If ack and detection occur in the same cycle,
//   detection wins and hang_o stays 1.
// - A new episode that reaches the limit while hang_o is still 1 overwrites the capture
//   registers and increments hang_events_o.
// - tx_i drop mid-stall, with no xfer: treated as the end of the episode; the framing FSM is unchanged.
// - Reset mid-episode: every register returns to its reset value immediately (async).
// - The watchdog is purely observational; it adds no latency to the link.
// CONFIGURATION
// - LINK_HANG_WATCHDOG_LOG_EN defined:
//   - $display at detection: "[t ms] [WD XXxYY-PORT] Hang detected, header H, pos P".
//   - $display at episode end: "... Released after N cycles".
//   - t = $time()/1_000_000.0, formatted as %7.3f.
// - Not defined: no display code is compiled; signal behaviour is identical.
// TESTING
// - Reset, idle link, 1000 cycles -> all outputs stay 0.
// - Header 0x00000102, size 2, service 1, payload 0xAA with eop; credit always 1
//   -> no hang; FSM back in HEADER.
// - STALL_LIMIT=8: header 0x00000203 accepted, then cr_rx_i=0 for 20 cycles with tx_i=1
//   -> hang_o rises 8 cycles after the stall starts; hang_pos_o=1; hang_header_o=0x00000203;
//      hang_events_o=1; hang_len_o=20 when released.
// - Stall of 7 cycles, then credit -> no detection; stall_cnt restarts at 0.
// - hang_ack_i pulse 3 cycles after detection -> hang_o=0 next cycle; hang_active_o stays 1
//   until xfer. Ack in the same cycle as a second detection -> hang_o stays 1; hang_events_o=2.
// - rst_ni low during an active hang -> all outputs 0 immediately; the next packet is framed from HEADER.

Source files
------------

// File: rtl/link_hang_watchdog_if.sv
// Credit-link wires seen by the watchdog plus its hang report; the master side drives the link and ack.
// Purely a bundle: no logic, so no latency and no flow control of its own.
interface link_hang_watchdog_if #(
    parameter int CNT_W = 16
);
    logic             tx;
    logic             cr_rx;
    logic             eop_tx;
    logic [31:0]      data_tx;
    logic             hang_ack;
    logic             hang;
    logic             hang_active;
    logic [31:0]      hang_header;
    logic [1:0]       hang_pos;
    logic [CNT_W-1:0] hang_len;
    logic [CNT_W-1:0] hang_events;

    modport master (
        output tx, cr_rx, eop_tx, data_tx, hang_ack,
        input  hang, hang_active, hang_header, hang_pos, hang_len, hang_events
    );

    modport slave (
        input  tx, cr_rx, eop_tx, data_tx, hang_ack,
        output hang, hang_active, hang_header, hang_pos, hang_len, hang_events
    );
endinterface

// File: rtl/link_hang_watchdog.sv
// Passive hang monitor on a credit link; report registers update one edge after STALL_LIMIT stall cycles.
// Never drives or backpressures the link; define LINK_HANG_WATCHDOG_LOG_EN to add $display logging.
module link_hang_watchdog #(
    parameter logic [15:0] ADDRESS     = 16'b0,
    parameter string       PORT        = "",
    parameter int          STALL_LIMIT = 64,
    parameter int          CNT_W       = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    link_hang_watchdog_if.slave  lnk
);
    typedef enum logic [1:0] {
        ST_HEADER  = 2'd0,
        ST_SIZE    = 2'd1,
        ST_SERVICE = 2'd2,
        ST_PAYLOAD = 2'd3
    } pos_e;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STALL_LIMIT - 1);

    pos_e             state, state_nxt;
    logic [31:0]      hdr_q;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             xfer, stall, detect;

    logic             hang_q, active_q;
    logic [31:0]      header_q;
    logic [1:0]       pos_q;
    logic [CNT_W-1:0] len_q, events_q;

    assign xfer    = lnk.tx & lnk.cr_rx;
    assign stall   = lnk.tx & ~lnk.cr_rx;
    assign cnt_inc = (stall_cnt == CNT_MAX) ? CNT_MAX : stall_cnt + CNT_W'(1);
    // The active guard keeps a saturated counter from re-firing within one episode.
    assign detect  = stall & (stall_cnt == LIMIT_M1) & ~active_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_HEADER;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (xfer) begin
            if (lnk.eop_tx) begin
                state_nxt = ST_HEADER;
            end else begin
                case (state)
                    ST_HEADER:  state_nxt = ST_SIZE;
                    ST_SIZE:    state_nxt = ST_SERVICE;
                    ST_SERVICE: state_nxt = ST_PAYLOAD;
                    ST_PAYLOAD: state_nxt = ST_PAYLOAD;
                    default:    state_nxt = ST_HEADER;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hdr_q     <= '0;
            stall_cnt <= '0;
            hang_q    <= 1'b0;
            active_q  <= 1'b0;
            header_q  <= '0;
            pos_q     <= '0;
            len_q     <= '0;
            events_q  <= '0;
        end else begin
            if (xfer && state == ST_HEADER) begin
                hdr_q <= lnk.data_tx;
            end
            stall_cnt <= stall ? cnt_inc : '0;
            if (detect) begin
                // A header still waiting for credit has not reached hdr_q yet.
                hang_q   <= 1'b1;
                active_q <= 1'b1;
                header_q <= (state == ST_HEADER) ? lnk.data_tx : hdr_q;
                pos_q    <= state;
                len_q    <= cnt_inc;
                events_q <= (events_q == CNT_MAX) ? CNT_MAX : events_q + CNT_W'(1);
            end else begin
                if (lnk.hang_ack) begin
                    hang_q <= 1'b0;
                end
                if (!stall) begin
                    active_q <= 1'b0;
                end else if (active_q) begin
                    len_q <= cnt_inc;
                end
            end
        end
    end

    assign lnk.hang        = hang_q;
    assign lnk.hang_active = active_q;
    assign lnk.hang_header = header_q;
    assign lnk.hang_pos    = pos_q;
    assign lnk.hang_len    = len_q;
    assign lnk.hang_events = events_q;

`ifdef LINK_HANG_WATCHDOG_LOG_EN
    always @(posedge clk_i) begin
        if (rst_ni && detect) begin
            $display("[%7.3f ms] [WD %02hx%s%02hx-%s] Hang detected, header %08h, pos %0d",
                     $time / 1_000_000.0, ADDRESS[15:8], "x", ADDRESS[7:0], PORT,
                     (state == ST_HEADER) ? lnk.data_tx : hdr_q, state);
        end
        if (rst_ni && active_q && !stall) begin
            $display("[%7.3f ms] [WD %02hx%s%02hx-%s] Released after %0d cycles",
                     $time / 1_000_000.0, ADDRESS[15:8], "x", ADDRESS[7:0], PORT, len_q);
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^ADDRESS ^ (PORT == "");
`endif
endmodule

// File: tb/tb_link_hang_watchdog.sv
// Bench for link_hang_watchdog: vector table, multi-cycle corner sequences, then random traffic vs a model.
module tb_link_hang_watchdog;
    localparam int LIMIT = 8;
    localparam int CNT_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    link_hang_watchdog_if #(.CNT_W(CNT_W)) lif ();

    link_hang_watchdog #(
        .ADDRESS    (16'h0102),
        .PORT       ("east"),
        .STALL_LIMIT(LIMIT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .lnk   (lif)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: packet flit index and stall run length as plain integers.
    int          m_run, m_idx, m_pos, m_len, m_ev;
    logic [31:0] m_hdr, m_header;
    logic        m_hang, m_act;

    typedef struct {
        int          n;
        logic        tx, cr, eop;
        logic [31:0] d;
        logic        ack;
        logic        e_hang, e_act;
        logic [31:0] e_hdr;
        int          e_pos, e_len, e_ev;
    } vec_t;
    vec_t tbl[$];

    task automatic model_reset();
        m_run = 0; m_idx = 0; m_pos = 0; m_len = 0; m_ev = 0;
        m_hdr = '0; m_header = '0; m_hang = 1'b0; m_act = 1'b0;
    endtask

    task automatic model_update(input logic tx, input logic cr, input logic eop,
                                input logic [31:0] d, input logic ack);
        logic xfer, stall, det;
        xfer  = tx && cr;
        stall = tx && !cr;
        m_run = stall ? m_run + 1 : 0;
        det   = stall && (m_run == LIMIT);
        if (det) begin
            m_hang   = 1'b1;
            m_act    = 1'b1;
            m_header = (m_idx == 0) ? d : m_hdr;
            m_pos    = (m_idx > 3) ? 3 : m_idx;
            m_len    = LIMIT;
            if (m_ev < CMAX) m_ev++;
        end else begin
            if (ack) m_hang = 1'b0;
            if (!stall) m_act = 1'b0;
            else if (m_act) m_len = (m_run > CMAX) ? CMAX : m_run;
        end
        if (xfer) begin
            if (m_idx == 0) m_hdr = d;
            m_idx = eop ? 0 : m_idx + 1;
        end
    endtask

    task automatic step(input logic tx, input logic cr, input logic eop,
                        input logic [31:0] d, input logic ack);
        lif.tx = tx; lif.cr_rx = cr; lif.eop_tx = eop; lif.data_tx = d; lif.hang_ack = ack;
        @(posedge clk);
        #1;
        model_update(tx, cr, eop, d, ack);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic eh, input logic ea,
                           input logic [31:0] ehd, input int ep, input int el, input int ev);
        chk({tag, ".hang"},   32'(lif.hang),        32'(eh));
        chk({tag, ".active"}, 32'(lif.hang_active), 32'(ea));
        chk({tag, ".header"}, lif.hang_header,      ehd);
        chk({tag, ".pos"},    32'(lif.hang_pos),    32'(ep));
        chk({tag, ".len"},    32'(lif.hang_len),    32'(el));
        chk({tag, ".events"}, 32'(lif.hang_events), 32'(ev));
    endtask

    task automatic do_reset();
        lif.tx = 1'b0; lif.cr_rx = 1'b0; lif.eop_tx = 1'b0; lif.data_tx = '0; lif.hang_ack = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic add(input int n, input logic tx, input logic cr, input logic eop,
                       input logic [31:0] d, input logic ack, input logic eh, input logic ea,
                       input logic [31:0] ehd, input int ep, input int el, input int ev);
        tbl.push_back('{n, tx, cr, eop, d, ack, eh, ea, ehd, ep, el, ev});
    endtask

    initial begin
        lif.tx = 1'b0; lif.cr_rx = 1'b0; lif.eop_tx = 1'b0; lif.data_tx = '0; lif.hang_ack = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        //  n     tx cr eop data          ack  hang act header        pos len ev
        add(1000, 0, 0, 0, 32'h0,         0,   0,   0,  32'h0,        0,  0,  0);
        add(1,    1, 1, 0, 32'h00000102,  0,   0,   0,  32'h0,        0,  0,  0);
        add(1,    1, 1, 0, 32'h2,         0,   0,   0,  32'h0,        0,  0,  0);
        add(1,    1, 1, 0, 32'h1,         0,   0,   0,  32'h0,        0,  0,  0);
        add(1,    1, 1, 1, 32'hAA,        0,   0,   0,  32'h0,        0,  0,  0);
        add(1,    1, 1, 0, 32'h00000203,  0,   0,   0,  32'h0,        0,  0,  0);
        add(7,    1, 0, 0, 32'h5,         0,   0,   0,  32'h0,        0,  0,  0);
        add(1,    1, 0, 0, 32'h5,         0,   1,   1,  32'h00000203, 1,  8,  1);
        add(12,   1, 0, 0, 32'h5,         0,   1,   1,  32'h00000203, 1,  20, 1);
        add(1,    1, 1, 0, 32'h5,         0,   1,   0,  32'h00000203, 1,  20, 1);
        add(7,    1, 0, 0, 32'h1,         0,   1,   0,  32'h00000203, 1,  20, 1);
        add(1,    1, 1, 0, 32'h1,         0,   1,   0,  32'h00000203, 1,  20, 1);
        add(7,    1, 0, 0, 32'h9,         0,   1,   0,  32'h00000203, 1,  20, 1);
        add(1,    1, 0, 0, 32'h9,         0,   1,   1,  32'h00000203, 3,  8,  2);
        add(1,    0, 0, 0, 32'h0,         0,   1,   0,  32'h00000203, 3,  8,  2);
        add(1,    0, 0, 0, 32'h0,         1,   0,   0,  32'h00000203, 3,  8,  2);
        add(1,    1, 1, 1, 32'h9,         0,   0,   0,  32'h00000203, 3,  8,  2);
        add(8,    1, 0, 0, 32'hCAFE0001,  0,   1,   1,  32'hCAFE0001, 0,  8,  3);
        add(1,    1, 1, 0, 32'hCAFE0001,  0,   1,   0,  32'hCAFE0001, 0,  8,  3);

        foreach (tbl[i]) begin
            repeat (tbl[i].n) step(tbl[i].tx, tbl[i].cr, tbl[i].eop, tbl[i].d, tbl[i].ack);
            chk_all($sformatf("vec%0d", i), tbl[i].e_hang, tbl[i].e_act, tbl[i].e_hdr,
                    tbl[i].e_pos, tbl[i].e_len, tbl[i].e_ev);
        end

        // Ack during an ongoing hang, then ack coinciding with the next detection.
        do_reset();
        step(1, 1, 0, 32'h00000203, 0);
        repeat (7) step(1, 0, 0, 32'h5, 0);
        chk("ack.pre_hang", 32'(lif.hang), 32'd0);
        step(1, 0, 0, 32'h5, 0);
        chk("ack.detect", 32'(lif.hang), 32'd1);
        repeat (2) step(1, 0, 0, 32'h5, 0);
        step(1, 0, 0, 32'h5, 1);
        chk("ack.cleared", 32'(lif.hang), 32'd0);
        chk("ack.still_active", 32'(lif.hang_active), 32'd1);
        repeat (2) step(1, 0, 0, 32'h5, 0);
        chk_all("ack.hold", 0, 1, 32'h00000203, 1, 13, 1);
        step(1, 1, 0, 32'h5, 0);
        chk("ack.release", 32'(lif.hang_active), 32'd0);
        repeat (7) step(1, 0, 0, 32'h6, 0);
        step(1, 0, 0, 32'h6, 1);
        chk_all("ack.same_cycle", 1, 1, 32'h00000203, 2, 8, 2);

        // Async reset in the middle of an active hang.
        do_reset();
        step(1, 1, 0, 32'h00000203, 0);
        repeat (10) step(1, 0, 0, 32'h5, 0);
        chk("rst.pre_active", 32'(lif.hang_active), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_all("rst.async", 0, 0, 0, 0, 0, 0);
        lif.tx = 1'b0; lif.cr_rx = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        step(1, 1, 0, 32'h00000077, 0);
        repeat (LIMIT) step(1, 0, 0, 32'h5, 0);
        chk_all("rst.reframe", 1, 1, 32'h00000077, 1, LIMIT, 1);

        // Random traffic in phases of varying credit starvation.
        do_reset();
        begin
            int cr_pct;
            cr_pct = 50;
            for (int c = 0; c < 4000; c++) begin
                if (c % 64 == 0) begin
                    case ($urandom_range(0, 2))
                        0:       cr_pct = 5;
                        1:       cr_pct = 50;
                        default: cr_pct = 95;
                    endcase
                end
                step(($urandom % 100) < 90, ($urandom % 100) < cr_pct,
                     ($urandom % 4) == 0, $urandom, ($urandom % 100) < 4);
                chk_all($sformatf("rnd%0d", c), m_hang, m_act, m_header, m_pos, m_len, m_ev);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
